bus_ctrl: RTL

BUS_CTRL -- requirements
Module: bus_ctrl

---
 rtl/bus_ctrl.sv | 74 +++++++
 1 files changed

// File: rtl/bus_ctrl.sv
// bus_ctrl: CPU bus decode, wait-state sequencing and read-data steering.
// Optional BUS_CTRL_STRESS_EN gates ready with a free-running toggle flop.
module bus_ctrl #(
  parameter int MEM_WAIT = 0,
  parameter int IO_WAIT  = 0,
  parameter int HYP_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] address_next,
  input  logic        write_next,
  input  logic        mapper_busy,
  input  logic [7:0]  mem_data_i,
  input  logic [7:0]  io_data_i,
  input  logic [7:0]  hyp_data_i,
  output logic        ready,
  output logic [7:0]  data_i,
  output logic        mem_we,
  output logic        io_we,
  output logic        io_cs,
  output logic        hyper_cs,
  output logic [1:0]  bus_device
);
  typedef enum logic {ST_ADDR, ST_WAIT} state_t;
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d, wsel;
  logic [1:0]  bus_device_q, bus_device_d, dev;
  logic        rdy;
`ifdef BUS_CTRL_STRESS_EN
  logic        toggle_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) toggle_q <= 1'b0;
    else       toggle_q <= ~toggle_q;
`endif
  always_comb begin
    io_cs    = address_next == 20'h0BFFC;
    hyper_cs = ~io_cs & (address_next[19:6] == {12'h0D6, 2'b01});
    wsel     = io_cs ? 3'(IO_WAIT) : hyper_cs ? 3'(HYP_WAIT) : 3'(MEM_WAIT);
    dev      = io_cs ? 2'd1 : hyper_cs ? 2'd2 : 2'd0;
    rdy      = ~mapper_busy & ((state_q == ST_ADDR) ? (wsel == 3'd0) : (cnt_q == 3'd0));
`ifdef BUS_CTRL_STRESS_EN
    ready    = ~reset & rdy & ~toggle_q;
`else
    ready    = ~reset & rdy;
`endif
    state_d  = state_q;
    cnt_d    = cnt_q;
    if (state_q == ST_ADDR) begin
      if (~mapper_busy && wsel != 3'd0) begin
        state_d = ST_WAIT;
        cnt_d   = wsel - 3'd1;
      end
    end else begin
      cnt_d = (cnt_q != 3'd0) ? cnt_q - 3'd1 : cnt_q;
      if (ready) state_d = ST_ADDR;
    end
    bus_device_d = ready ? dev : bus_device_q;
    mem_we       = write_next & ready & ~io_cs & ~hyper_cs;
    io_we        = write_next & ready & io_cs;
    bus_device   = bus_device_q;
    data_i       = (bus_device_q == 2'd1) ? io_data_i :
                   (bus_device_q == 2'd2) ? hyp_data_i : mem_data_i;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q      <= ST_ADDR;
      cnt_q        <= 3'd0;
      bus_device_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bus_device_q <= bus_device_d;
    end
endmodule
